// File: rtl/xrv_bus_arb.sv
// Two-requester arbiter (instruction fetch vs. load/store) for one shared
// memory port. Load/store normally wins, but a streak counter bounds how
// many load/store grants may be taken back-to-back while a fetch waits.
module xrv_bus_arb #(
    parameter int unsigned MAX_LS_STREAK = 2
) (
    input  logic        clk,
    input  logic        rstb,
    // fetch requester
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ready,
    output logic [31:0] if_rdata,
    // load/store requester
    input  logic        ls_rd_req,
    input  logic        ls_wr_req,
    input  logic [31:0] ls_addr,
    input  logic [3:0]  ls_be,
    input  logic [31:0] ls_wdata,
    output logic        ls_ready,
    output logic [31:0] ls_rdata,
    // shared memory port
    output logic        m_req,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [3:0]  m_be,
    output logic [31:0] m_wdata,
    input  logic        m_ready,
    input  logic [31:0] m_rdata,
    // status
    output logic        grant_ls,
    output logic        proto_err
);

    typedef enum logic [1:0] {IDLE, IF_XFER, LS_XFER} state_e;

    localparam logic [2:0] MAX_S = 3'(MAX_LS_STREAK);

    state_e      state_q, state_d;
    logic [2:0]  streak_q, streak_d;
    logic        m_we_q, m_we_d;
    logic [31:0] m_addr_q, m_addr_d;
    logic [3:0]  m_be_q, m_be_d;
    logic [31:0] m_wdata_q, m_wdata_d;
    logic        proto_err_q, proto_err_d;

    logic ls_any;
    logic ls_win;

    // Load/store wins unless a fetch is waiting and the streak is used up.
    assign ls_any = ls_rd_req | ls_wr_req;
    assign ls_win = ls_any & (~if_req | (streak_q < MAX_S));

    // Next-state, grant capture and streak bookkeeping.
    always_comb begin
        state_d     = state_q;
        streak_d    = streak_q;
        m_we_d      = m_we_q;
        m_addr_d    = m_addr_q;
        m_be_d      = m_be_q;
        m_wdata_d   = m_wdata_q;
        proto_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (ls_win) begin
                    state_d     = LS_XFER;
                    // A simultaneous read+write is illegal; the write wins.
                    m_we_d      = ls_wr_req;
                    m_addr_d    = ls_addr;
                    m_be_d      = ls_be;
                    m_wdata_d   = ls_wdata;
                    proto_err_d = ls_rd_req & ls_wr_req;
                    if (!if_req)
                        streak_d = 3'd0;
                    else if (streak_q < MAX_S)
                        streak_d = streak_q + 3'd1;
                end else if (if_req) begin
                    state_d   = IF_XFER;
                    m_we_d    = 1'b0;
                    m_addr_d  = if_addr;
                    m_be_d    = 4'hF;
                    m_wdata_d = 32'd0;
                    streak_d  = 3'd0;
                end
            end
            IF_XFER, LS_XFER: begin
                // Completion always drops back to IDLE: no back-to-back grants.
                if (m_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and captured transfer registers; reset aborts any transfer.
    always_ff @(posedge clk or posedge rstb) begin
        if (rstb) begin
            state_q     <= IDLE;
            streak_q    <= 3'd0;
            m_we_q      <= 1'b0;
            m_addr_q    <= 32'd0;
            m_be_q      <= 4'd0;
            m_wdata_q   <= 32'd0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            streak_q    <= streak_d;
            m_we_q      <= m_we_d;
            m_addr_q    <= m_addr_d;
            m_be_q      <= m_be_d;
            m_wdata_q   <= m_wdata_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign m_req     = (state_q != IDLE);
    assign m_we      = m_we_q;
    assign m_addr    = m_addr_q;
    assign m_be      = m_be_q;
    assign m_wdata   = m_wdata_q;
    assign grant_ls  = (state_q == LS_XFER);
    assign proto_err = proto_err_q;

    // Ready is steered to the owner only; a stray m_ready in IDLE goes nowhere.
    assign if_ready  = m_ready & (state_q == IF_XFER);
    assign ls_ready  = m_ready & (state_q == LS_XFER);
    assign if_rdata  = m_rdata;
    assign ls_rdata  = m_rdata;

endmodule
